imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Owns the single port of the 1024x32 instruction memory and shares it between the core fetch path and a byte-stream program loader.
//  In RUN, converts the core's byte PC to a word index, issues a 1-cycle synchronous read and returns instr + valid.
//  In LOAD, stalls the core, packs incoming bytes little-endian into words and writes them from word 0 upward.
// PARAMETERS
//  DEPTH   1024          words in instruction memory
//  ADDR_W  10            word-index width, = clog2(DEPTH)
//  NOP     32'h00000013  addi x0,x0,0; returned on invalid or faulting fetch
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst_n        in   1       asynchronous active-low reset
//  fetch_pc     in   32      core byte address, sampled in RUN
//  fetch_instr  out  32      instruction for the fetch_pc of the previous cycle
//  fetch_valid  out  1       fetch_instr is valid this cycle
//  fetch_err    out  1       previous fetch_pc misaligned or >= DEPTH*4
//  core_stall   out  1       core must hold PC and not commit
//  load_start   in   1       pulse, begin load of load_words words
//  load_words   in   ADDR_W+1  word count, sampled with load_start
//  load_abort   in   1       abandon load in progress
//  byte_valid   in   1       loader byte present
//  byte_data    in   8       loader byte
//  byte_ready   out  1       byte accepted when valid & ready
//  load_done    out  1       1-cycle pulse, load completed
//  load_err     out  1       1-cycle pulse, load aborted
//  mem_en       out  1       memory port enable
//  mem_we       out  1       memory write enable
//  mem_addr     out  ADDR_W  memory word index
//  mem_wdata    out  32      memory write data
//  mem_rdata    in   32      memory read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  Reset: state RUN, word_idx 0, byte_cnt 0. Outputs: fetch_valid 0, fetch_instr NOP, fetch_err 0, core_stall 0, byte_ready 0, load_done 0, load_err 0, mem_en 0, mem_we 0.
//  FSM states: RUN, LOAD, WRITE, DRAIN.
//  RUN: mem_en 1, mem_we 0, mem_addr = fetch_pc[ADDR_W+1:2].
//   Next cycle: fetch_valid 1, fetch_instr = mem_rdata.
//   If fetch_pc[1:0] != 0 or fetch_pc >= DEPTH*4: mem_en 0; next cycle fetch_instr NOP, fetch_err 1, fetch_valid 1.
//  RUN & load_start & load_words != 0 -> LOAD.
//   n = min(load_words, DEPTH); core_stall 1 from the next cycle; load_start with load_words == 0 is ignored.
//  LOAD: byte_ready 1, mem_en 0, fetch_valid 0. Byte k (0..3) goes to word[8k+7:8k]. Fourth byte -> WRITE.
//  WRITE (1 cycle): byte_ready 0, mem_en 1, mem_we 1, mem_addr word_idx, mem_wdata packed word.
//   word_idx+1 == n -> DRAIN; otherwise word_idx++, byte_cnt 0, -> LOAD.
//  DRAIN (1 cycle): load_done 1, mem_en 0 -> RUN.
//   core_stall drops on RUN entry; first fetch_valid follows 1 cycle later.
//  load_abort in LOAD or WRITE: WRITE still completes its write; partial word discarded; load_err pulse; -> RUN. load_abort in RUN is ignored.
//  load_start outside RUN is ignored. load_abort and a 4th byte in the same cycle: abort wins, no write.
//  Async reset mid-load clears all state. Memory words already written remain.
//  core_stall = 1 in LOAD, WRITE, DRAIN.
// STRUCTURE
//  Shared package imem_pkg: NOP constant, state encoding (RUN/LOAD/WRITE/DRAIN), DEPTH/ADDR_W defaults.
//  Sub-module imem_word_packer: byte_cnt, little-endian shift register, word_full flag, clear input.
//  Memory array is external, instantiated alongside.
// TESTING
//  Fetch: reset, preload mem[3]=32'hDEADBEEF, pc=0xC -> 1 cycle later fetch_valid 1, instr DEADBEEF, err 0.
//  Bad fetch: pc=0x6 and pc=0x1000 -> instr 0x00000013, fetch_err 1, mem_en 0.
//  Load: load_words=2, bytes 13 00 00 00 B3 00 10 00 -> mem[0]=00000013, mem[1]=001000B3.
//   Then: load_done pulse, stall drops, fetch at pc=4 returns 001000B3.
//  Stall gaps: byte_valid toggled randomly during 3-word load -> same contents.
//   core_stall continuous LOAD..DRAIN; no fetch_valid while stalled.
//  Abort: abort after 6 bytes of a 2-word load -> mem[0] written, mem[1] unchanged, load_err pulse, RUN.
//  Reset mid-WRITE: rst_n low -> all outputs at reset values; load_start in LOAD ignored; load_words=0 ignored.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory
// load controller.
package imem_pkg;

   localparam int          DEPTH  = 1024;
   localparam int          ADDR_W = 10;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs loader bytes little-endian into one 32-bit word.
module imem_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take_i,
   input  logic        clear_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o,
   output logic        last_o,
   output logic        full_o
);

   logic [1:0]  cnt_q;
   logic [31:0] sh_q;
   logic        full_q;

   // Each byte enters at the top, so byte 0 ends up in bits [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sh_q   <= '0;
         full_q <= 1'b0;
      end else if (clear_i) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else if (take_i) begin
         sh_q   <= {data_i, sh_q[31:8]};
         cnt_q  <= cnt_q + 2'd1;
         full_q <= (cnt_q == 2'd3);
      end
   end

   assign word_o = sh_q;
   assign last_o = (cnt_q == 2'd3);
   assign full_o = full_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction-memory port between core fetch and a
// byte-stream program loader.
module imem_load_ctrl
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       fetch_pc,
   output logic [31:0]       fetch_instr,
   output logic              fetch_valid,
   output logic              fetch_err,
   output logic              core_stall,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_words,
   input  logic              load_abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              load_done,
   output logic              load_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [31:0]     PC_LIMIT = 32'(DEPTH * 4);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   n_q, n_d, idx_nxt;
   logic              active_q;
   logic              fvalid_q, fvalid_d;
   logic              ferr_q, ferr_d;
   logic              rd_ok_q, rd_ok_d;
   logic              pc_bad, byte_take, pk_clear;
   logic              pk_last, pk_full;
   logic [31:0]       pk_word;

   assign pc_bad    = (fetch_pc[1:0] != 2'b00) || (fetch_pc >= PC_LIMIT);
   assign byte_take = (state_q == LOAD) && byte_valid && !load_abort;
   assign idx_nxt   = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

   imem_word_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .take_i  (byte_take),
      .clear_i (pk_clear),
      .data_i  (byte_data),
      .word_o  (pk_word),
      .last_o  (pk_last),
      .full_o  (pk_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         idx_q    <= '0;
         n_q      <= '0;
         active_q <= 1'b0;
         fvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         rd_ok_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         active_q <= 1'b1;
         fvalid_q <= fvalid_d;
         ferr_q   <= ferr_d;
         rd_ok_q  <= rd_ok_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      n_d        = n_q;
      fvalid_d   = 1'b0;
      ferr_d     = 1'b0;
      rd_ok_d    = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = fetch_pc[ADDR_W+1:2];
      mem_wdata  = pk_word;
      byte_ready = 1'b0;
      load_done  = 1'b0;
      load_err   = 1'b0;
      core_stall = 1'b1;
      pk_clear   = 1'b1;
      unique case (state_q)
         RUN: begin
            core_stall = 1'b0;
            mem_en     = active_q && !pc_bad;
            fvalid_d   = active_q;
            ferr_d     = active_q && pc_bad;
            rd_ok_d    = mem_en;
            if (load_start && (load_words != '0)) begin
               state_d = LOAD;
               idx_d   = '0;
               n_d     = (load_words > DEPTH_W) ? DEPTH_W : load_words;
            end
         end
         LOAD: begin
            byte_ready = 1'b1;
            pk_clear   = load_abort;
            if (load_abort) begin
               load_err = 1'b1;
               state_d  = RUN;
            end else if (byte_take && pk_last) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_en   = pk_full;
            mem_we   = pk_full;
            mem_addr = idx_q;
            if (load_abort) begin
               load_err = 1'b1;
               state_d  = RUN;
            end else if (idx_nxt == n_q) begin
               state_d = DRAIN;
            end else begin
               idx_d   = idx_nxt[ADDR_W-1:0];
               state_d = LOAD;
            end
         end
         DRAIN: begin
            load_done = 1'b1;
            state_d   = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Fetch results are only presented while the core owns the port.
   assign fetch_valid = fvalid_q && (state_q == RUN);
   assign fetch_err   = ferr_q && (state_q == RUN);
   assign fetch_instr = rd_ok_q ? mem_rdata : NOP;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with an external memory model.
module tb_imem_load_ctrl;
   import imem_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       fetch_pc = 32'h0000_000C;
   logic [31:0]       fetch_instr;
   logic              fetch_valid, fetch_err, core_stall;
   logic              load_start = 1'b0;
   logic [ADDR_W:0]   load_words = '0;
   logic              load_abort = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = '0;
   logic              byte_ready, load_done, load_err;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       model_mem [DEPTH];
   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [31:0]       pre_data = '0;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   since_rst;
   logic exp_stall = 1'b0;
   logic prev_issue = 1'b0;
   logic [31:0] prev_pc = '0;

   always #5 clk = ~clk;

   imem_load_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_valid(fetch_valid), .fetch_err(fetch_err),
      .core_stall(core_stall),
      .load_start(load_start), .load_words(load_words),
      .load_abort(load_abort),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready),
      .load_done(load_done), .load_err(load_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
      return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
   endfunction

   function automatic logic pc_is_bad(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc >= DEPTH * 4);
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) since_rst <= 0;
      else since_rst <= since_rst + 1;

   // Cycle-level fetch model: a fetch issued while the core runs shows
   // up one cycle later unless the core has been stalled meanwhile.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst fetch_valid", 32'(fetch_valid), 0);
         check("rst fetch_instr", fetch_instr, NOP);
         check("rst fetch_err", 32'(fetch_err), 0);
         check("rst core_stall", 32'(core_stall), 0);
         check("rst byte_ready", 32'(byte_ready), 0);
         check("rst load_done", 32'(load_done), 0);
         check("rst load_err", 32'(load_err), 0);
         check("rst mem_en", 32'(mem_en), 0);
         check("rst mem_we", 32'(mem_we), 0);
         prev_issue = 1'b0;
      end else begin
         check("core_stall", 32'(core_stall), 32'(exp_stall));
         if (prev_issue && !exp_stall) begin
            check("fetch_valid", 32'(fetch_valid), 1);
            check("fetch_err", 32'(fetch_err), 32'(pc_is_bad(prev_pc)));
            check("fetch_instr", fetch_instr,
                  pc_is_bad(prev_pc) ? NOP : model_mem[prev_pc / 4]);
         end else begin
            check("fetch_valid idle", 32'(fetch_valid), 0);
         end
         prev_issue = (since_rst >= 1) && !exp_stall;
         prev_pc    = fetch_pc;
      end
   end

   task automatic start_load(input logic [ADDR_W:0] w);
      @(posedge clk); #1;
      load_start = 1'b1;
      load_words = w;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (w != 0) exp_stall = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      logic rdy;
      logic ok;
      ok = 1'b0;
      rdy = 1'b0;
      if (gap) repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         rdy = byte_ready;
         @(posedge clk); #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      byte_valid = 1'b0;
      if (!ok) check("byte accept timeout", 32'(rdy), 1);
   endtask

   task automatic wait_done();
      logic got;
      got = 1'b0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (load_done) begin
            got = 1'b1;
            break;
         end
      end
      check("load_done pulse", 32'(got), 1);
      @(posedge clk); #1;
      exp_stall = 1'b0;
      @(negedge clk);
      check("load_done width", 32'(load_done), 0);
   endtask

   logic [7:0] bq [$];

   initial begin
      for (int i = 0; i < 8; i++) begin
         pre_we   = 1'b1;
         pre_addr = ADDR_W'(i);
         pre_data = (i == 3) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
         model_mem[i] = pre_data;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;
      rst_n  = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("fetch 0xC valid", 32'(fetch_valid), 1);
      check("fetch 0xC instr", fetch_instr, 32'hDEAD_BEEF);
      check("fetch 0xC err", 32'(fetch_err), 0);

      @(posedge clk); #1;
      fetch_pc = 32'h6;
      @(negedge clk);
      check("pc 0x6 mem_en", 32'(mem_en), 0);
      @(negedge clk);
      check("pc 0x6 instr", fetch_instr, 32'h0000_0013);
      check("pc 0x6 err", 32'(fetch_err), 1);
      @(posedge clk); #1;
      fetch_pc = 32'h1000;
      @(negedge clk);
      check("pc 0x1000 mem_en", 32'(mem_en), 0);
      @(negedge clk);
      check("pc 0x1000 instr", fetch_instr, 32'h0000_0013);
      check("pc 0x1000 err", 32'(fetch_err), 1);

      fetch_pc = 32'h4;
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
      start_load(2);
      foreach (bq[i]) send_byte(bq[i], 1'b0);
      wait_done();
      for (int w = 0; w < 2; w++)
         model_mem[w] = pack(bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]);
      check("load mem[0]", mem[0], 32'h0000_0013);
      check("load mem[1]", mem[1], 32'h0010_00B3);
      check("after load valid", 32'(fetch_valid), 0);
      @(negedge clk);
      check("pc 4 valid", 32'(fetch_valid), 1);
      check("pc 4 instr", fetch_instr, 32'h0010_00B3);

      bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
      start_load(3);
      send_byte(bq[0], 1'b1);
      load_start = 1'b1;
      load_words = 1;
      send_byte(bq[1], 1'b0);
      load_start = 1'b0;
      for (int i = 2; i < 12; i++) send_byte(bq[i], 1'b1);
      wait_done();
      for (int w = 0; w < 3; w++) begin
         model_mem[w] = pack(bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]);
         check("gap load word", mem[w], model_mem[w]);
      end
      check("gap mem[2]", mem[2], 32'h0C0B_0A09);
      fetch_pc = 32'h8;
      repeat (3) @(negedge clk);

      fetch_pc = 32'h0;
      bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      start_load(2);
      foreach (bq[i]) send_byte(bq[i], 1'b0);
      load_abort = 1'b1;
      @(negedge clk);
      check("abort load_err", 32'(load_err), 1);
      @(posedge clk); #1;
      load_abort = 1'b0;
      exp_stall  = 1'b0;
      @(negedge clk);
      check("abort err width", 32'(load_err), 0);
      model_mem[0] = pack(bq[0], bq[1], bq[2], bq[3]);
      check("abort mem[0]", mem[0], 32'hDDCC_BBAA);
      check("abort mem[1]", mem[1], 32'h0807_0605);

      start_load(1);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      send_byte(8'h77, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'h88;
      load_abort = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      load_abort = 1'b0;
      exp_stall  = 1'b0;
      repeat (2) @(negedge clk);
      check("abort+4th mem[0]", mem[0], 32'hDDCC_BBAA);

      bq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      start_load(2);
      foreach (bq[i]) send_byte(bq[i], 1'b0);
      rst_n     = 1'b0;
      exp_stall = 1'b0;
      @(negedge clk);
      check("rst mid-write mem_we", 32'(mem_we), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_mem[0] = pack(bq[0], bq[1], bq[2], bq[3]);
      check("rst mem[0]", mem[0], 32'h2423_2221);
      check("rst mem[1]", mem[1], 32'h0807_0605);

      start_load(0);
      @(negedge clk);
      check("zero words byte_ready", 32'(byte_ready), 0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
